mlp_weight_bank_mem: RTL and testbench
======================================

# mlp_weight_bank_mem

Banked, parametrised weight store for the MLP datapath: NUM_BANKS independent memory banks sharing one row address, so one read returns the weights for NUM_BANKS parallel MAC lanes in a single access. A built-in load sequencer accepts a valid/ready word stream and writes it to consecutive flat addresses, interleaved across banks, starting from a programmable base. It replaces the single-port, single-word weight memory between the host/DMA loader and the MAC array.

## Interface
- ADDR_WIDTH, 6, row address bits per bank (depth 2^ADDR_WIDTH rows)
- DATA_WIDTH, 32, bits per weight word
- NUM_BANKS, 4, banks / MAC lanes; power of two, at least 1
- Derived: BANK_W = clog2(NUM_BANKS), minimum 0; FLAT_W = ADDR_WIDTH+BANK_W; CNT_W = FLAT_W+1

- clk  in  1  clock, all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- load_start  in  1  start pulse; sampled only in IDLE
- load_base  in  FLAT_W  flat word address of the first word to load
- load_len  in  CNT_W  number of words to load (0 up to NUM_BANKS*2^ADDR_WIDTH)
- load_busy  out  1  high in LOAD
- load_done  out  1  one-cycle pulse when a load completes
- wr_valid  in  1  stream word valid
- wr_ready  out  1  sequencer accepts a word
- wr_data  in  DATA_WIDTH  stream word
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  row index
- rd_data  out  NUM_BANKS*DATA_WIDTH  row contents; bank 0 in the LSBs
- rd_valid  out  1  rd_data updated this cycle

## Operation
- Flat address mapping: bank = flat[BANK_W-1:0], row = flat[FLAT_W-1:BANK_W].
- FSM states IDLE, LOAD, DONE.
  - IDLE: on load_start, latch load_base into the address pointer and load_len into the remaining-word counter. If load_len = 0, go to DONE; otherwise go to LOAD.
  - LOAD: wr_ready = 1. A word transfers when wr_valid && wr_ready. Each transfer writes wr_data to the bank/row of the pointer, increments the pointer, and decrements the counter. When the transfer with counter = 1 occurs, go to DONE.
  - DONE: load_done = 1 for exactly one cycle, then return to IDLE.
- load_start is ignored in LOAD and DONE.
- The pointer wraps modulo NUM_BANKS*2^ADDR_WIDTH, so the address after the last one is flat 0.
- Read: on rd_en, all banks at rd_addr are registered into rd_data. rd_valid is high the following cycle. rd_data holds its value until the next rd_en.
- Reads are allowed in any state.
- A read and a write to the same bank/row in the same cycle return the OLD data (read-first). The write still commits.
- Memory contents have no reset and persist across rst. Unwritten locations read as X in simulation.

## Timing
- Reset values: load_busy 0, load_done 0, wr_ready 0, rd_valid 0, rd_data 0; FSM in IDLE; pointer and counter 0.
- Latencies:
  - load_start to wr_ready: 1 cycle.
  - Last transfer to load_done: 1 cycle.
  - load_start with len 0 to load_done: 1 cycle, with no wr_ready cycle.
- Throughput: one word per cycle while wr_valid is held high. A load of N words occupies N+2 cycles when not stalled.
- Read latency is 1 cycle, and one read can be issued every cycle.
- rst in mid-load aborts immediately: FSM to IDLE, no load_done pulse. Words already written remain.

## Configuration
- WMEM_PARITY_EN defined:
  - Each bank stores an extra even-parity bit per word, computed on write.
  - On each read, parity is checked for all banks. Output rd_parity_err (1 bit) is registered alongside rd_valid and is high if any bank mismatches.
  - Reset value of rd_parity_err is 0.
- WMEM_PARITY_EN undefined: no parity storage and no rd_parity_err port. Behaviour is otherwise identical.

## Structure
- Shared package mlp_pkg holds:
  - the FSM state enum (WMEM_IDLE, WMEM_LOAD, WMEM_DONE);
  - the clog2 helper function;
  - the default width constants.
- One sub-module, mlp_wmem_bank: single bank with one synchronous write port and a registered read-first read port, plus the optional parity bit. It is instantiated NUM_BANKS times by generate.
- The top level contains the load FSM, the address pointer and counter, and the bank write-enable decode.

## Test plan
All scenarios use ADDR_WIDTH=6, DATA_WIDTH=32, NUM_BANKS=4.
- Basic load and read:
  - Stimulus: load_base=0, load_len=8, stream 0x100..0x107 with wr_valid held high.
  - Response: load_done exactly 1 cycle after the 8th transfer.
  - Read row 0 -> rd_data = {0x103,0x102,0x101,0x100}, rd_valid 1 cycle after rd_en.
  - Read row 1 -> rd_data = {0x107,0x106,0x105,0x104}.
- Unaligned base with stall:
  - Stimulus: load_base=5, load_len=3, wr_valid deasserted for 2 cycles after the first word.
  - Response: words land at bank1/row1, bank2/row1, bank3/row1. Bank0/row1 is unchanged. The counter does not decrement during the stall.
- Wrap-around:
  - Stimulus: load_base=255, load_len=2, data 0xAAAA0001, 0xAAAA0002.
  - Response: bank3/row63 = 0xAAAA0001; bank0/row0 = 0xAAAA0002.
- Zero-length and ignored restart:
  - Stimulus: load_len=0.
  - Response: load_done on the next cycle, wr_ready never high.
  - Stimulus: load_start asserted during LOAD.
  - Response: the active load is unaffected.
- Read-first collision and reset abort:
  - Stimulus: rd_en at row 2 in the same cycle a write hits bank0/row2.
  - Response: old word returned; the next read returns the new word.
  - Stimulus: rst after 3 of 6 words.
  - Response: all outputs at reset values, no load_done, the 3 written words persist.
- WMEM_PARITY_EN:
  - Stimulus: force a flipped stored bit in bank2.
  - Response: rd_parity_err = 1 together with rd_valid. A clean read gives rd_parity_err = 0.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP weight store: load FSM states, default
// widths, and an elaboration-time ceil(log2) helper.
package mlp_pkg;

  localparam int unsigned WMEM_ADDR_WIDTH = 6;
  localparam int unsigned WMEM_DATA_WIDTH = 32;
  localparam int unsigned WMEM_NUM_BANKS  = 4;

  typedef enum logic [1:0] {
    WMEM_IDLE,
    WMEM_LOAD,
    WMEM_DONE
  } wmem_state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mlp_wmem_bank.sv
// Single weight bank: one synchronous write port and a registered,
// read-first read port. With WMEM_PARITY_EN defined, each word carries an
// even-parity bit that is checked on every read.
module mlp_wmem_bank
  import mlp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WMEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
`ifdef WMEM_PARITY_EN
  ,
  output logic                  perr_o
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef WMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [WORD_W-1:0]     wword;
  logic [WORD_W-1:0]     rword;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Stored word: data, plus the even-parity bit when enabled
  always_comb begin
`ifdef WMEM_PARITY_EN
    wword = {^wdata_i, wdata_i};
`else
    wword = wdata_i;
`endif
  end

  assign rword = mem_q[raddr_i];

  // Memory array write; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wword;
  end

  // Registered read; sees pre-write contents on a same-row collision
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rword[DATA_WIDTH-1:0];
    end
  end

  assign rdata_o = rdata_q;

`ifdef WMEM_PARITY_EN
  logic perr_q;

  // Parity check registered alongside the read data
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (re_i) begin
      perr_q <= ^rword;
    end
  end

  assign perr_o = perr_q;
`endif

endmodule

// File: rtl/mlp_weight_bank_mem.sv
// Banked MLP weight store with a valid/ready load sequencer. NUM_BANKS banks
// share one row address; loads write consecutive flat addresses interleaved
// across banks (bank = low bits, row = high bits), wrapping at the top.
// Optional macro WMEM_PARITY_EN adds per-word parity and rd_parity_err.
module mlp_weight_bank_mem
  import mlp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WMEM_DATA_WIDTH,
  parameter int unsigned NUM_BANKS  = WMEM_NUM_BANKS,
  localparam int unsigned BANK_W    = clog2(NUM_BANKS),
  localparam int unsigned FLAT_W    = ADDR_WIDTH + BANK_W,
  localparam int unsigned CNT_W     = FLAT_W + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic [FLAT_W-1:0]               load_base,
  input  logic [CNT_W-1:0]                load_len,
  output logic                            load_busy,
  output logic                            load_done,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            rd_en,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
  output logic                            rd_valid
`ifdef WMEM_PARITY_EN
  ,
  output logic                            rd_parity_err
`endif
);

  wmem_state_e       state_q, state_d;
  logic [FLAT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              xfer;
  logic              rd_valid_q;

  logic [ADDR_WIDTH-1:0] wr_row;
  logic [FLAT_W-1:0]     wr_bank;
  logic [NUM_BANKS-1:0]  bank_we;

  assign xfer = (state_q == WMEM_LOAD) && wr_valid;

  // Load FSM next-state, pointer/counter update and status outputs
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    load_busy = 1'b0;
    wr_ready  = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      WMEM_IDLE: begin
        if (load_start) begin
          ptr_d   = load_base;
          cnt_d   = load_len;
          state_d = (load_len == '0) ? WMEM_DONE : WMEM_LOAD;
        end
      end
      WMEM_LOAD: begin
        load_busy = 1'b1;
        wr_ready  = 1'b1;
        if (xfer) begin
          ptr_d = ptr_q + FLAT_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = WMEM_DONE;
        end
      end
      WMEM_DONE: begin
        load_done = 1'b1;
        state_d   = WMEM_IDLE;
      end
      default: state_d = WMEM_IDLE;
    endcase
  end

  // FSM state, pointer and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WMEM_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read-valid flag, one cycle behind rd_en
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_en;
  end

  assign rd_valid = rd_valid_q;

  // Modulo/shift rather than slicing keeps NUM_BANKS == 1 (BANK_W == 0) legal
  assign wr_row  = ADDR_WIDTH'(ptr_q >> BANK_W);
  assign wr_bank = ptr_q % FLAT_W'(NUM_BANKS);

`ifdef WMEM_PARITY_EN
  logic [NUM_BANKS-1:0] bank_perr;
  assign rd_parity_err = |bank_perr;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_we[b] = xfer && (wr_bank == FLAT_W'(b));

    mlp_wmem_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bank_we[b]),
      .waddr_i (wr_row),
      .wdata_i (wr_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data[b*DATA_WIDTH +: DATA_WIDTH])
`ifdef WMEM_PARITY_EN
      ,
      .perr_o  (bank_perr[b])
`endif
    );
  end

endmodule

// File: tb/tb_mlp_weight_bank_mem.sv
// Self-checking bench for mlp_weight_bank_mem (ADDR_WIDTH=6, DATA_WIDTH=32,
// NUM_BANKS=4). A flat-array reference model predicts every output each
// cycle; directed tests add hand-computed literal checks.
module tb_mlp_weight_bank_mem;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int FW = 8;
  localparam int CW = 9;
  localparam int DEPTH = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_start;
  logic [FW-1:0]  load_base;
  logic [CW-1:0]  load_len;
  logic           load_busy;
  logic           load_done;
  logic           wr_valid;
  logic           wr_ready;
  logic [DW-1:0]  wr_data;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [NB*DW-1:0] rd_data;
  logic           rd_valid;
`ifdef WMEM_PARITY_EN
  logic           rd_parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mlp_weight_bank_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`ifdef WMEM_PARITY_EN
    ,
    .rd_parity_err (rd_parity_err)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat word array plus load bookkeeping
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_live = 0;
  bit          m_busy, m_done, was_busy, was_done;
  int          m_rem, m_ptr;
  bit          m_rv;
  logic [31:0] m_rdata [NB];
  bit          m_rknown [NB];

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_busy = 0; m_done = 0; m_rem = 0; m_ptr = 0; m_rv = 0;
      for (int b = 0; b < NB; b++) begin m_rdata[b] = '0; m_rknown[b] = 1; end
    end else if (m_live) begin
      was_busy = m_busy;
      was_done = m_done;
      m_done = 0;
      if (rd_en) begin
        for (int b = 0; b < NB; b++) begin
          m_rdata[b]  = m_mem[int'(rd_addr) * NB + b];
          m_rknown[b] = m_known[int'(rd_addr) * NB + b];
        end
      end
      m_rv = rd_en;
      if (was_busy && wr_valid) begin
        m_mem[m_ptr] = wr_data;
        m_known[m_ptr] = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end else if (!was_busy && !was_done && load_start) begin
        m_ptr = int'(load_base);
        m_rem = int'(load_len);
        if (m_rem == 0) m_done = 1;
        else            m_busy = 1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("load_busy", load_busy, m_busy);
      chk("wr_ready",  wr_ready,  m_busy);
      chk("load_done", load_done, m_done);
      chk("rd_valid",  rd_valid,  m_rv);
      for (int b = 0; b < NB; b++)
        if (m_rknown[b]) chk("rd_data_lane", rd_data[b*32 +: 32], m_rdata[b]);
    end
  end

  task automatic start_load(input int base, input int len);
    load_start = 1; load_base = FW'(base); load_len = CW'(len);
    @(negedge clk);
    load_start = 0;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1; wr_data = d;
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    if (!wr_ready) chk("send_timeout", 1'b0, 1'b1);
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((load_busy || load_done) && n < 50) begin @(negedge clk); n++; end
    if (load_busy || load_done) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic read_row(input int r);
    rd_en = 1; rd_addr = AW'(r);
    @(negedge clk);
    rd_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; load_start = 0; load_base = '0; load_len = '0;
    wr_valid = 0; wr_data = '0; rd_en = 0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", load_busy, 1'b0);
    chk("rst_ready", wr_ready, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 128'h0);
    rst = 0;
    @(negedge clk);

    // Basic load of 8 words, then two row reads
    start_load(0, 8);
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
    chk("basic_done_next", load_done, 1'b1);
    wait_idle();
    read_row(0);
    chk("basic_rv", rd_valid, 1'b1);
    chk("basic_row0", rd_data, 128'h00000103_00000102_00000101_00000100);
    read_row(1);
    chk("basic_row1", rd_data, 128'h00000107_00000106_00000105_00000104);
    @(negedge clk);
    chk("rv_drop", rd_valid, 1'b0);
    chk("rd_hold", rd_data, 128'h00000107_00000106_00000105_00000104);

    // Unaligned base with a two-cycle stall
    start_load(5, 3);
    send(32'h200);
    repeat (2) @(negedge clk);
    chk("stall_busy", load_busy, 1'b1);
    send(32'h201);
    send(32'h202);
    wait_idle();
    read_row(1);
    chk("unaligned_row1", rd_data, 128'h00000202_00000201_00000200_00000104);

    // Wrap-around past the last flat address
    start_load(255, 2);
    send(32'hAAAA0001);
    send(32'hAAAA0002);
    wait_idle();
    read_row(63);
    chk("wrap_b3r63", rd_data[127:96], 32'hAAAA0001);
    read_row(0);
    chk("wrap_b0r0", rd_data[31:0], 32'hAAAA0002);

    // Zero-length load
    start_load(0, 0);
    chk("zero_done", load_done, 1'b1);
    chk("zero_ready", wr_ready, 1'b0);
    @(negedge clk);
    chk("zero_done_end", load_done, 1'b0);

    // Restart attempt during an active load
    start_load(16, 4);
    send(32'h400);
    load_start = 1; load_base = 8'd40; load_len = 9'd1;
    send(32'h401);
    load_start = 0;
    send(32'h402);
    send(32'h403);
    wait_idle();
    read_row(4);
    chk("restart_row4", rd_data, 128'h00000403_00000402_00000401_00000400);

    // Read-first collision on bank0/row2
    start_load(8, 4);
    for (int i = 0; i < 4; i++) send(32'h300 + 32'(i));
    wait_idle();
    start_load(8, 1);
    wr_valid = 1; wr_data = 32'h00C0FFEE; rd_en = 1; rd_addr = 6'd2;
    @(negedge clk);
    wr_valid = 0; rd_en = 0;
    chk("collide_old", rd_data[31:0], 32'h300);
    wait_idle();
    read_row(2);
    chk("collide_new", rd_data[31:0], 32'h00C0FFEE);

    // Reset abort after 3 of 6 words
    start_load(32, 6);
    send(32'h500); send(32'h501); send(32'h502);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", load_busy, 1'b0);
    chk("abort_ready", wr_ready, 1'b0);
    chk("abort_done", load_done, 1'b0);
    chk("abort_rd_data", rd_data, 128'h0);
    rst = 0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", load_done, 1'b0);
    end
    read_row(8);
    chk("abort_persist", rd_data[95:0], 96'h00000502_00000501_00000500);

`ifdef WMEM_PARITY_EN
    read_row(0);
    chk("parity_clean", rd_parity_err, 1'b0);
    m_known[6] = 0;
    dut.g_bank[2].u_bank.mem_q[1][3] = ~dut.g_bank[2].u_bank.mem_q[1][3];
    read_row(1);
    chk("parity_rv", rd_valid, 1'b1);
    chk("parity_err", rd_parity_err, 1'b1);
    read_row(0);
    chk("parity_clean2", rd_parity_err, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
